fetch_predict: RTL and testbench

Instruction-fetch stage with integrated branch prediction. It holds the program counter, drives the instruction-memory address, and presents the fetched instruction with its PC, PC+4 and prediction to the IF/ID pipeline register (dummy6 `*_IF` inputs). A direct-mapped BTB with 2-bit saturating counters selects the next PC. Later stages update the BTB with resolved branches and redirect fetch on a misprediction.

---
 rtl/fetch_predict.sv | 109 ++++++++++
 tb/tb_fetch_predict.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_predict.sv
// Instruction-fetch stage: PC register, direct-mapped BTB with 2-bit counters.
// Ports: CLK/RESET, STALL, redirect (Request_Alt_PC/Alt_PC), BTB update bus,
//        IM address/data, and fetched instr/PC/PC+4/prediction to IF/ID.
module fetch_predict #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          IDX_BITS = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        Request_Alt_PC,
    input  logic [31:0] Alt_PC,
    input  logic        Update_valid,
    input  logic [31:0] Update_PC,
    input  logic        Update_taken,
    input  logic [31:0] Update_target,
    output logic [31:0] Instr_address_2IM,
    input  logic [31:0] Instr1_fIM,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4,
    output logic        Branch_prediction_OUT,
    output logic [1:0]  Branch_predictions_OUT
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 32 - IDX_BITS - 2;

    logic [31:0]         pc_q;
    logic [31:0]         pc_d;
    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic                lk_hit;
    logic                lk_taken;
    logic [31:0]         pc_plus4;

    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]    up_tag;
    logic                up_hit;
    logic                unused_up_lsb;

    assign lk_idx   = pc_q[IDX_BITS+1:2];
    assign lk_tag   = pc_q[31:IDX_BITS+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];
    assign pc_plus4 = pc_q + 32'd4;

    assign up_idx = Update_PC[IDX_BITS+1:2];
    assign up_tag = Update_PC[31:IDX_BITS+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign unused_up_lsb = ^Update_PC[1:0];

    assign Instr_address_2IM      = pc_q;
    assign Instr_PC_OUT           = pc_q;
    assign Instr_PC_Plus4         = pc_plus4;
    assign Instr1_OUT             = Instr1_fIM;
    assign Branch_prediction_OUT  = lk_taken;
    assign Branch_predictions_OUT = lk_hit ? ctr_q[lk_idx] : 2'b01;

    // Redirect beats stall: a resolved misprediction must never be lost.
    always_comb begin
        pc_d = pc_plus4;
        if (Request_Alt_PC) begin
            pc_d = Alt_PC;
        end else if (STALL) begin
            pc_d = pc_q;
        end else if (lk_taken) begin
            pc_d = target_q[lk_idx];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            pc_q <= pc_d;
            if (Update_valid) begin
                if (up_hit) begin
                    if (Update_taken) begin
                        target_q[up_idx] <= Update_target;
                        if (ctr_q[up_idx] != 2'b11) begin
                            ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
                        end
                    end else if (ctr_q[up_idx] != 2'b00) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
                    end
                end else if (Update_taken) begin
                    // Miss on a taken branch replaces whatever aliased here.
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= Update_target;
                    ctr_q[up_idx]    <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_predict.sv
// Bench for fetch_predict: reference model of PC/BTB plus a PC scoreboard.
// Covers reset, stall/redirect priority, BTB allocate/saturate/alias, wrap.
module tb_fetch_predict;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        Request_Alt_PC;
    logic [31:0] Alt_PC;
    logic        Update_valid;
    logic [31:0] Update_PC;
    logic        Update_taken;
    logic [31:0] Update_target;
    logic [31:0] Instr_address_2IM;
    logic [31:0] Instr1_fIM;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4;
    logic        Branch_prediction_OUT;
    logic [1:0]  Branch_predictions_OUT;

    fetch_predict dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .STALL                  (STALL),
        .Request_Alt_PC         (Request_Alt_PC),
        .Alt_PC                 (Alt_PC),
        .Update_valid           (Update_valid),
        .Update_PC              (Update_PC),
        .Update_taken           (Update_taken),
        .Update_target          (Update_target),
        .Instr_address_2IM      (Instr_address_2IM),
        .Instr1_fIM             (Instr1_fIM),
        .Instr1_OUT             (Instr1_OUT),
        .Instr_PC_OUT           (Instr_PC_OUT),
        .Instr_PC_Plus4         (Instr_PC_Plus4),
        .Branch_prediction_OUT  (Branch_prediction_OUT),
        .Branch_predictions_OUT (Branch_predictions_OUT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] sb[$];

    logic [31:0] m_pc;
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic [1:0]  m_ctr   [16];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'hBFC00000;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 2'b01;
        end
        sb.delete();
    endtask

    // Called at posedge+1: drive, check lookup, advance model, check PC.
    task automatic step(input logic st, input logic rq,
                        input logic [31:0] alt, input logic uv,
                        input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg);
        logic [3:0]  i;
        logic [3:0]  ui;
        logic        hit;
        logic        uhit;
        logic [1:0]  c;
        logic [31:0] nxt;
        STALL          = st;
        Request_Alt_PC = rq;
        Alt_PC         = alt;
        Update_valid   = uv;
        Update_PC      = upc;
        Update_taken   = ut;
        Update_target  = utg;
        Instr1_fIM     = $urandom;
        #1;
        i   = m_pc[5:2];
        hit = m_valid[i] && (m_tag[i] == m_pc[31:6]);
        c   = hit ? m_ctr[i] : 2'b01;
        chk("im_addr", Instr_address_2IM, m_pc);
        chk("pc_out", Instr_PC_OUT, m_pc);
        chk("pc_plus4", Instr_PC_Plus4, m_pc + 32'd4);
        chk("pred", {31'd0, Branch_prediction_OUT}, {31'd0, hit && c[1]});
        chk("ctr", {30'd0, Branch_predictions_OUT}, {30'd0, c});
        chk("instr", Instr1_OUT, Instr1_fIM);
        if (rq) nxt = alt;
        else if (st) nxt = m_pc;
        else if (hit && c[1]) nxt = m_tgt[i];
        else nxt = m_pc + 32'd4;
        if (uv) begin
            ui   = upc[5:2];
            uhit = m_valid[ui] && (m_tag[ui] == upc[31:6]);
            if (uhit && ut) begin
                m_tgt[ui] = utg;
                if (m_ctr[ui] < 2'b11) m_ctr[ui] = m_ctr[ui] + 2'd1;
            end else if (uhit) begin
                if (m_ctr[ui] > 2'b00) m_ctr[ui] = m_ctr[ui] - 2'd1;
            end else if (ut) begin
                m_valid[ui] = 1'b1;
                m_tag[ui]   = upc[31:6];
                m_tgt[ui]   = utg;
                m_ctr[ui]   = 2'b10;
            end
        end
        m_pc = nxt;
        sb.push_back(nxt);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else chk("pc_next", Instr_PC_OUT, sb.pop_front());
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input logic [31:0] a);
        step(0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic t,
                       input logic [31:0] tg);
        step(1, 0, 0, 1, pc, t, tg);
    endtask

    initial begin
        RESET = 1'b0;
        STALL = 0; Request_Alt_PC = 0; Alt_PC = 0;
        Update_valid = 0; Update_PC = 0; Update_taken = 0;
        Update_target = 0; Instr1_fIM = 32'h1234_5678;
        m_reset();
        @(posedge CLK);
        #1;
        chk("rst_pc", Instr_PC_OUT, 32'hBFC00000);
        chk("rst_im", Instr_address_2IM, 32'hBFC00000);
        chk("rst_p4", Instr_PC_Plus4, 32'hBFC00004);
        chk("rst_pred", {31'd0, Branch_prediction_OUT}, 32'd0);
        chk("rst_ctr", {30'd0, Branch_predictions_OUT}, 32'd1);
        RESET = 1'b1;
        run(3);

        // Mid-run asynchronous reset
        jump(32'h00400010);
        chk("pre_rst_pc", Instr_PC_OUT, 32'h00400010);
        #2;
        RESET = 1'b0;
        Instr1_fIM = 32'hCAFE_F00D;
        #1;
        chk("mrst_pc", Instr_PC_OUT, 32'hBFC00000);
        chk("mrst_p4", Instr_PC_Plus4, 32'hBFC00004);
        chk("mrst_pred", {31'd0, Branch_prediction_OUT}, 32'd0);
        chk("mrst_ctr", {30'd0, Branch_predictions_OUT}, 32'd1);
        chk("mrst_instr", Instr1_OUT, 32'hCAFE_F00D);
        step_in_reset();
        RESET = 1'b1;
        m_reset();
        run(3);
        chk("seq_pc", Instr_PC_OUT, 32'hBFC0000C);

        // Stall then stall+redirect
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0);
        chk("stall_pc", Instr_PC_OUT, 32'hBFC0000C);
        step(1, 1, 32'h00400100, 0, 0, 0, 0);
        chk("st_redir", Instr_PC_OUT, 32'h00400100);

        // Allocate and hit
        upd(32'h00400020, 1, 32'h00400080);
        jump(32'h00400020);
        chk("bt_pred", {31'd0, Branch_prediction_OUT}, 32'd1);
        chk("bt_ctr", {30'd0, Branch_predictions_OUT}, 32'd2);
        run(1);
        chk("bt_tgt", Instr_PC_OUT, 32'h00400080);

        // Saturation
        for (int k = 0; k < 3; k++) upd(32'h00400020, 1, 32'h00400080);
        jump(32'h00400020);
        chk("sat_hi", {30'd0, Branch_predictions_OUT}, 32'd3);
        for (int k = 0; k < 4; k++) upd(32'h00400020, 0, 0);
        chk("sat_lo", {30'd0, Branch_predictions_OUT}, 32'd0);
        chk("sat_pred", {31'd0, Branch_prediction_OUT}, 32'd0);
        run(1);
        chk("nt_next", Instr_PC_OUT, 32'h00400024);

        // Aliasing
        upd(32'h00400060, 1, 32'h00400200);
        jump(32'h00400020);
        chk("alias_miss", {30'd0, Branch_predictions_OUT}, 32'd1);
        jump(32'h00400060);
        chk("alias_hit", {30'd0, Branch_predictions_OUT}, 32'd2);

        // Same-edge update and lookup: lookup sees old contents
        step(0, 0, 0, 1, 32'h00400060, 0, 0);
        chk("same_old", Instr_PC_OUT, 32'h00400200);
        jump(32'h00400060);
        chk("same_new", {30'd0, Branch_predictions_OUT}, 32'd1);

        // Wrap
        jump(32'hFFFFFFFC);
        run(1);
        chk("wrap", Instr_PC_OUT, 32'h00000000);
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Hold reset across an edge with a redirect pending; it must be ignored.
    task automatic step_in_reset();
        Request_Alt_PC = 1'b1;
        Alt_PC         = 32'h00400300;
        @(posedge CLK);
        #1;
        chk("rst_hold", Instr_PC_OUT, 32'hBFC00000);
        Request_Alt_PC = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", n_chk);
        $fatal(1);
    end

endmodule
